// File: rtl/traffic_pkg.sv
// Shared types and defaults for the intersection controller and its
// pedestrian-phase scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WALK  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_GAP   = 3'd4
    } ped_state_e;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_WALK_TIME  = 10;
    localparam int DEF_CLEAR_TIME = 5;
    localparam int DEF_MIN_GAP    = 15;
    localparam int DEF_CNT_W      = 5;

    // Light-controller modes; ALL_RED is what walk_ack confirms.
    typedef enum logic [1:0] {
        LM_NORMAL  = 2'd0,
        LM_ALL_RED = 2'd1,
        LM_PED     = 2'd2,
        LM_FLASH   = 2'd3
    } light_mode_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set pending bit searching
// upward from last_grant+1, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDW-1:0]   last_grant,
    output logic [IDW-1:0]   id,
    output logic             valid
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    int                 start_s;
    int                 hit_s;

    // Rotate so the search start sits at bit 0, then take the lowest set bit.
    always_comb begin
        start_s = (int'(last_grant) >= N_REQ - 1) ? 0 : int'(last_grant) + 1;
        dbl_s   = {pending, pending};
        rot_s   = N_REQ'(dbl_s >> start_s);
        valid   = |rot_s;
        hit_s   = 0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            hit_s = rot_s[j] ? j : hit_s;
        end
        id = (start_s + hit_s >= N_REQ) ? IDW'(start_s + hit_s - N_REQ)
                                        : IDW'(start_s + hit_s);
    end

endmodule

// File: rtl/ped_walk_scheduler.sv
// Pedestrian-phase scheduler: latches button presses, arbitrates them
// round-robin and sequences REQ -> WALK -> CLEAR -> GAP per crossing.
module ped_walk_scheduler
    import traffic_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int WALK_TIME  = DEF_WALK_TIME,
    parameter int CLEAR_TIME = DEF_CLEAR_TIME,
    parameter int MIN_GAP    = DEF_MIN_GAP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         ped_btn,
    input  logic                     walk_ack,
    output logic                     walk_req,
    output logic [$clog2(N_REQ)-1:0] walk_id,
    output logic [N_REQ-1:0]         walk,
    output logic                     flash,
    output logic                     walk_done,
    output logic [N_REQ-1:0]         pending
);

    localparam int               IDW     = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] LSB_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    ped_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] btn_q;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] press_s;
    logic [N_REQ-1:0] clr_s;
    logic [N_REQ-1:0] id_onehot_s;
    logic [IDW-1:0]   last_grant_q;
    logic [IDW-1:0]   pick_id_s;
    logic             pick_valid_s;
    logic             walk_req_q;
    logic [IDW-1:0]   walk_id_q;
    logic [N_REQ-1:0] walk_q;
    logic             flash_q;
    logic             walk_done_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .id         (pick_id_s),
        .valid      (pick_valid_s)
    );

    assign id_onehot_s = LSB_ONE << walk_id_q;

    // A press coinciding with its own ack is absorbed: the clear wins.
    always_comb begin
        press_s = ped_btn & ~btn_q;
        if (state_q == ST_REQ && walk_ack) begin
            clr_s = id_onehot_s;
        end else begin
            clr_s = N_REQ'(0);
        end
        pending_d = (pending_q | press_s) & ~clr_s;
    end

    // Button edge detect and pending-press register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q     <= N_REQ'(0);
            pending_q <= N_REQ'(0);
        end else begin
            btn_q     <= ped_btn;
            pending_q <= pending_d;
        end
    end

    // Phase FSM with down-counter; every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_W'(0);
            last_grant_q <= IDW'(N_REQ - 1);
            walk_req_q   <= 1'b0;
            walk_id_q    <= IDW'(0);
            walk_q       <= N_REQ'(0);
            flash_q      <= 1'b0;
            walk_done_q  <= 1'b0;
        end else begin
            walk_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_q    <= ST_REQ;
                        walk_req_q <= 1'b1;
                        walk_id_q  <= pick_id_s;
                    end
                end
                ST_REQ: begin
                    if (walk_ack) begin
                        state_q      <= ST_WALK;
                        walk_req_q   <= 1'b0;
                        last_grant_q <= walk_id_q;
                        cnt_q        <= CNT_W'(WALK_TIME - 1);
                        walk_q       <= id_onehot_s;
                    end
                end
                ST_WALK: begin
                    if (cnt_q == CNT_W'(0)) begin
                        state_q <= ST_CLEAR;
                        walk_q  <= N_REQ'(0);
                        flash_q <= 1'b1;
                        cnt_q   <= CNT_W'(CLEAR_TIME - 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == CNT_W'(0)) begin
                        state_q     <= ST_GAP;
                        flash_q     <= 1'b0;
                        walk_done_q <= 1'b1;
                        cnt_q       <= CNT_W'(MIN_GAP - 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(0)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    walk_req_q <= 1'b0;
                    walk_q     <= N_REQ'(0);
                    flash_q    <= 1'b0;
                end
            endcase
        end
    end

    assign walk_req  = walk_req_q;
    assign walk_id   = walk_id_q;
    assign walk      = walk_q;
    assign flash     = flash_q;
    assign walk_done = walk_done_q;
    assign pending   = pending_q;

endmodule

// File: doc/ped_walk_scheduler.md
# ped_walk_scheduler

Pedestrian-phase scheduler for the intersection light controller. It latches crossing-button presses from `N_REQ` crosswalks and arbitrates them round-robin. It asks the light controller for an all-red window through a req/ack handshake, then sequences the walk and clearance (flashing don't-walk) phases. A minimum gap is enforced before the next pedestrian phase so vehicle traffic is never starved.

## Interface
Parameters:
- `N_REQ`, 4: number of crosswalk requesters (2..8)
- `WALK_TIME`, 10: cycles `walk[id]` is held (≥1)
- `CLEAR_TIME`, 5: cycles `flash` is held (≥1)
- `MIN_GAP`, 15: cycles after a phase before a new `walk_req` may issue (≥1)
- `CNT_W`, 5: phase counter width; must hold max(WALK_TIME, CLEAR_TIME, MIN_GAP)−1

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `ped_btn`  in  N_REQ  synchronous button levels; rising edge = press
- `walk_ack`  in  1  light controller has reached all-red; sampled only in REQ
- `walk_req`  out  1  request for pedestrian window
- `walk_id`  out  clog2(N_REQ)  crosswalk being served; stable while `walk_req`=1
- `walk`  out  N_REQ  one-hot walk lamp
- `flash`  out  1  clearance (flashing don't-walk) for `walk_id`
- `walk_done`  out  1  one-cycle pulse: phase over, controller may resume
- `pending`  out  N_REQ  latched, unserved presses

## Operation
- States: IDLE, REQ, WALK, CLEAR, GAP. Reset → IDLE.
- Press detect:
  - `btn_q` registers `ped_btn` and resets to 0.
  - A button held through reset is counted as a press on the first active edge.
- `pending[i]` is set on a press of i. It is cleared on the cycle `walk_ack` is accepted for `walk_id`=i.
  - If a press of i coincides with its own ack cycle, the clear wins and the press is absorbed.
  - A press during WALK, CLEAR or GAP of the same id re-arms `pending`.
- IDLE: if `pending`≠0, go to REQ, assert `walk_req`, and load `walk_id` = the first set bit searching upward from `last_grant`+1, with wrap.
  - `last_grant` resets to N_REQ−1, so id 0 has first priority after reset.
- REQ: hold `walk_req` and `walk_id`; new presses do not change `walk_id`. No timeout.
  - On `walk_ack`=1: go to WALK, drop `walk_req`, set `last_grant` = `walk_id`, load counter = WALK_TIME−1.
- WALK: `walk[walk_id]`=1; decrement counter; at 0 go to CLEAR with counter = CLEAR_TIME−1.
- CLEAR: `flash`=1; at 0 go to GAP with counter = MIN_GAP−1 and `walk_done`=1 for that first GAP cycle.
- GAP: all lamps 0; at 0 go to IDLE.
- `walk_ack` outside REQ is ignored.
- Counter arithmetic is unsigned CNT_W bits and never underflows, because transitions occur at 0.
- Reset mid-phase: all outputs drop to 0 asynchronously, and pending presses are discarded.

## Timing
- All outputs are registered; no combinational path from input to output.
- Reset values: `walk_req`=0, `walk_id`=0, `walk`=0, `flash`=0, `walk_done`=0, `pending`=0.
- Press sampled at edge k:
  - `pending[i]`=1 after k.
  - `walk_req`=1 after k+1.
- Ack sampled at edge m:
  - `walk[id]` high for edges m+1 … m+WALK_TIME.
  - `flash` high for the next CLEAR_TIME cycles.
  - `walk_done` high for 1 cycle.
  - Earliest next `walk_req` is MIN_GAP cycles after the last `flash` cycle.
- `walk` and `flash` are never high simultaneously. At most one `walk` bit is high.

## Structure
- Shared package `traffic_pkg`:
  - state enum (IDLE/REQ/WALK/CLEAR/GAP)
  - default durations
  - the light-controller mode encodings it coordinates with
- Sub-module `rr_pick`: combinational round-robin selector with inputs `pending` and `last_grant`, outputs `id` and `valid`.
- The top level holds the FSM, counter, edge detect and pending register.

## Test plan
- Reset hold: `reset`=0 with `ped_btn`=4'b1111 → all outputs 0. Release → `pending`=4'b1111 one cycle later, then `walk_req`=1 with `walk_id`=0.
- Single press: `ped_btn[2]` pulsed, ack 3 cycles after `walk_req` → `walk`=4'b0100 for exactly 10 cycles, `flash` 5 cycles, `walk_done` one pulse, no `walk_req` for 15 cycles.
- Round-robin: press 1 and 3 together; after id 1 is served press 0 → order served 1, 3, 0.
- Ack stall: withhold `walk_ack` 50 cycles while pressing other buttons → `walk_req` stays 1 and `walk_id` stays unchanged; pending bits accumulate.
- Same-id press on ack cycle: press id 1 on the ack cycle → `pending[1]`=0 afterwards. Press id 1 during WALK → `pending[1]`=1 and it is served again after GAP.
- Reset mid-WALK: assert `reset` in cycle 4 of WALK → `walk`=0 immediately, state IDLE, `pending`=0. Spurious `walk_ack` in IDLE is ignored.
